// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and the host FSM state type for the
// conv_128_32 host-side stream driver.
//   DATA_WIDTH_X/F : element widths of the X and F vectors
//   X_SIZE, F_SIZE : elements per job
//   Y_SIZE         : valid-convolution result count
//   ACC_SIZE       : signed result width
package conv_pkg;

  localparam int DATA_WIDTH_X = 8;
  localparam int DATA_WIDTH_F = 8;
  localparam int X_SIZE       = 128;
  localparam int F_SIZE       = 32;
  localparam int ACC_SIZE     = 21;
  localparam int Y_SIZE       = X_SIZE - F_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } host_state_t;

endpackage

// File: rtl/conv_stream_host_stream_tx.sv
// stream_tx: element buffer plus valid/ready master that replays the buffer
// from index 0 to SIZE-1 once per launch.
//   clk, reset         : clock, async active-low reset
//   wr_en/addr/data    : buffer write port (caller gates it to idle time)
//   launch             : restart transmission from element 0
//   m_valid/m_data     : registered stream outputs
//   m_ready            : downstream ready
//   finished           : set after the last beat transfers, cleared on launch
module stream_tx #(
  parameter  int WIDTH = 8,
  parameter  int SIZE  = 128,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             launch,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             finished
);

  localparam logic [AW-1:0] IDX_LAST = AW'(SIZE - 1);

  logic [WIDTH-1:0] mem [SIZE];

  logic [AW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fin_q, fin_d;
  logic             beat;
  logic [AW-1:0]    idx_inc;

  assign beat    = valid_q && m_ready;
  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Data is registered and preloaded with the next element on each
  // handshake so consecutive beats flow without a bubble.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    fin_d   = fin_q;
    if (launch) begin
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = mem[0];
      fin_d   = 1'b0;
    end else if (beat) begin
      if (idx_q == IDX_LAST) begin
        valid_d = 1'b0;
        fin_d   = 1'b1;
      end else begin
        idx_d  = idx_inc;
        data_d = mem[idx_inc];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
    end
  end

  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign finished = fin_q;

endmodule

// File: rtl/conv_stream_host.sv
// conv_stream_host: loads X/F vectors over a write port, streams them to the
// convolver on start, and captures the Y result stream for readback.
//   clk, reset                 : clock, async active-low reset
//   ld_wr_en/sel/addr/data     : load port (accepted only in IDLE)
//   start, y_stall             : job start pulse, Y-side throttle
//   busy, done                 : job status
//   m_*_x, m_*_f               : X and F master streams
//   s_valid_y/s_data_y/s_ready_y : Y slave stream
//   y_count, rd_addr, rd_data  : captured result count and readback
//
// state   | meaning
// IDLE    | load port open, waiting for start
// SEND    | X and F transmitters running, Y may already arrive
// COLLECT | both vectors sent, waiting for remaining Y beats
// DONE    | one-cycle completion pulse
module conv_stream_host #(
  parameter  int DATA_WIDTH_X = conv_pkg::DATA_WIDTH_X,
  parameter  int DATA_WIDTH_F = conv_pkg::DATA_WIDTH_F,
  parameter  int X_SIZE       = conv_pkg::X_SIZE,
  parameter  int F_SIZE       = conv_pkg::F_SIZE,
  parameter  int ACC_SIZE     = conv_pkg::ACC_SIZE,
  localparam int Y_SIZE       = X_SIZE - F_SIZE + 1,
  localparam int XAW          = $clog2(X_SIZE),
  localparam int FAW          = $clog2(F_SIZE),
  localparam int YAW          = $clog2(Y_SIZE),
  localparam int YCW          = $clog2(Y_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_wr_en,
  input  logic                    ld_sel,
  input  logic [XAW-1:0]          ld_addr,
  input  logic [DATA_WIDTH_X-1:0] ld_data,
  input  logic                    start,
  input  logic                    y_stall,
  output logic                    busy,
  output logic                    done,
  output logic                    m_valid_x,
  output logic [DATA_WIDTH_X-1:0] m_data_x,
  input  logic                    m_ready_x,
  output logic                    m_valid_f,
  output logic [DATA_WIDTH_F-1:0] m_data_f,
  input  logic                    m_ready_f,
  input  logic                    s_valid_y,
  input  logic [ACC_SIZE-1:0]     s_data_y,
  output logic                    s_ready_y,
  output logic [YCW-1:0]          y_count,
  input  logic [YAW-1:0]          rd_addr,
  output logic [ACC_SIZE-1:0]     rd_data
);
  import conv_pkg::*;

  localparam logic [XAW:0]   X_LIM  = (XAW + 1)'(X_SIZE);
  localparam logic [XAW:0]   F_LIM  = (XAW + 1)'(F_SIZE);
  localparam logic [YAW:0]   RD_LIM = (YAW + 1)'(Y_SIZE);
  localparam logic [YCW-1:0] Y_LAST = YCW'(Y_SIZE - 1);
  localparam logic [YCW-1:0] Y_FULL = YCW'(Y_SIZE);

  host_state_t state_q, state_d;

  logic           launch, ld_ok, x_wr, f_wr;
  logic           x_fin, f_fin;
  logic           y_hs, y_last;
  logic [YCW-1:0] y_count_q, y_count_d;
  logic [ACC_SIZE-1:0] ybuf [Y_SIZE];

  assign launch = (state_q == IDLE) && start;
  assign ld_ok  = (state_q == IDLE) && ld_wr_en;
  assign x_wr   = ld_ok && !ld_sel && ({1'b0, ld_addr} < X_LIM);
  assign f_wr   = ld_ok &&  ld_sel && ({1'b0, ld_addr} < F_LIM);

  stream_tx #(.WIDTH(DATA_WIDTH_X), .SIZE(X_SIZE)) u_tx_x (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (x_wr),
    .wr_addr  (ld_addr),
    .wr_data  (ld_data),
    .launch   (launch),
    .m_valid  (m_valid_x),
    .m_data   (m_data_x),
    .m_ready  (m_ready_x),
    .finished (x_fin)
  );

  stream_tx #(.WIDTH(DATA_WIDTH_F), .SIZE(F_SIZE)) u_tx_f (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (f_wr),
    .wr_addr  (ld_addr[FAW-1:0]),
    .wr_data  (ld_data[DATA_WIDTH_F-1:0]),
    .launch   (launch),
    .m_valid  (m_valid_f),
    .m_data   (m_data_f),
    .m_ready  (m_ready_f),
    .finished (f_fin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A fast convolver may deliver every Y beat while still in SEND; the
  // Y_FULL term keeps COLLECT from waiting for a beat that never comes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (x_fin && f_fin) state_d = COLLECT;
      COLLECT: if (y_last || (y_count_q == Y_FULL)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    s_ready_y = ((state_q == SEND) || (state_q == COLLECT)) && !y_stall &&
                (y_count_q != Y_FULL);
  end

  assign y_hs   = s_valid_y && s_ready_y;
  assign y_last = y_hs && (y_count_q == Y_LAST);

  always_comb begin
    y_count_d = y_count_q;
    if (launch)    y_count_d = '0;
    else if (y_hs) y_count_d = y_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) y_count_q <= '0;
    else        y_count_q <= y_count_d;
  end

  always_ff @(posedge clk) begin
    if (y_hs) ybuf[y_count_q[YAW-1:0]] <= s_data_y;
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < RD_LIM) rd_data = ybuf[rd_addr];
  end

  assign y_count = y_count_q;

endmodule

// File: tb/tb_conv_stream_host.sv
module tb_conv_stream_host;

  localparam int X_SIZE = 128;
  localparam int F_SIZE = 32;
  localparam int Y_SIZE = X_SIZE - F_SIZE + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_wr_en, ld_sel, start, y_stall;
  logic [6:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        busy, done;
  logic        m_valid_x, m_ready_x, m_valid_f, m_ready_f;
  logic [7:0]  m_data_x, m_data_f;
  logic        s_valid_y, s_ready_y;
  logic [20:0] s_data_y;
  logic [6:0]  y_count;
  logic [6:0]  rd_addr;
  logic [20:0] rd_data;

  int errors = 0;
  int checks = 0;

  int mx [X_SIZE];
  int mf [F_SIZE];
  int rx_x [X_SIZE];
  int rx_f [F_SIZE];
  int xq[$];
  int fq[$];
  int yq[$];

  conv_stream_host dut (
    .clk       (clk),
    .reset     (reset),
    .ld_wr_en  (ld_wr_en),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .y_stall   (y_stall),
    .busy      (busy),
    .done      (done),
    .m_valid_x (m_valid_x),
    .m_data_x  (m_data_x),
    .m_ready_x (m_ready_x),
    .m_valid_f (m_valid_f),
    .m_data_f  (m_data_f),
    .m_ready_f (m_ready_f),
    .s_valid_y (s_valid_y),
    .s_data_y  (s_data_y),
    .s_ready_y (s_ready_y),
    .y_count   (y_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered and left at posedge+1.
  task automatic load_all();
    for (int i = 0; i < X_SIZE; i++) begin
      ld_wr_en = 1'b1; ld_sel = 1'b0; ld_addr = 7'(i); ld_data = 8'(mx[i]);
      @(posedge clk); #1;
    end
    for (int j = 0; j < F_SIZE; j++) begin
      ld_wr_en = 1'b1; ld_sel = 1'b1; ld_addr = 7'(j); ld_data = 8'(mf[j]);
      @(posedge clk); #1;
    end
    // Out-of-range F address: aliases to F[8] if not dropped.
    ld_wr_en = 1'b1; ld_sel = 1'b1; ld_addr = 7'(F_SIZE + 8); ld_data = 8'd99;
    @(posedge clk); #1;
    ld_wr_en = 1'b0;
  endtask

  task automatic run_job(input int rmode, input bit smode, input bit inject, input int abort_at);
    int  xk, fk, yk, acc, exp_v;
    bit  got_done, pv_x, pr_x, pv_f, pr_f;
    logic [7:0] pd_x, pd_f;
    xq.delete(); fq.delete(); yq.delete();
    for (int i = 0; i < X_SIZE; i++) xq.push_back(mx[i]);
    for (int j = 0; j < F_SIZE; j++) fq.push_back(mf[j]);
    for (int k = 0; k < Y_SIZE; k++) begin
      acc = 0;
      for (int j = 0; j < F_SIZE; j++) acc += mx[k + j] * mf[j];
      yq.push_back(acc);
    end
    xk = 0; fk = 0; yk = 0; got_done = 1'b0;
    pv_x = 1'b0; pr_x = 1'b0; pv_f = 1'b0; pr_f = 1'b0; pd_x = '0; pd_f = '0;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      m_ready_x = (rmode == 0) || (cyc % 2 == 0);
      m_ready_f = (rmode == 0) || (cyc % 2 == 1);
      y_stall   = smode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject && cyc == 5) begin
        start = 1'b1; ld_wr_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'd55;
      end else begin
        start = 1'b0; ld_wr_en = 1'b0;
      end
      // Stand-in convolver: emit Y[yk] once its input window has arrived.
      if (yk < Y_SIZE && fk == F_SIZE && xk >= F_SIZE + yk) begin
        acc = 0;
        for (int j = 0; j < F_SIZE; j++) acc += rx_x[yk + j] * rx_f[j];
        s_valid_y = 1'b1; s_data_y = 21'(acc);
      end else begin
        s_valid_y = 1'b0;
      end

      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (!(m_valid_x && m_valid_f && busy))
          $display("FAIL first_valid: vx=%b vf=%b busy=%b, required 1 1 1", m_valid_x, m_valid_f, busy);
      end
      checks++;
      if (y_stall && s_ready_y) begin
        errors++; $display("FAIL stall_ready: s_ready_y=1 with y_stall=1, required 0");
      end
      if (pv_x && !pr_x) begin
        checks++;
        if (m_valid_x !== 1'b1 || m_data_x !== pd_x) begin
          errors++; $display("FAIL x_hold: valid=%b data=%0h, required 1 %0h", m_valid_x, m_data_x, pd_x);
        end
      end
      if (pv_f && !pr_f) begin
        checks++;
        if (m_valid_f !== 1'b1 || m_data_f !== pd_f) begin
          errors++; $display("FAIL f_hold: valid=%b data=%0h, required 1 %0h", m_valid_f, m_data_f, pd_f);
        end
      end
      if (m_valid_x && m_ready_x) begin
        checks++;
        if (xq.size() == 0) begin
          errors++; $display("FAIL x_extra: beat %0d beyond vector end", xk);
        end else begin
          exp_v = xq.pop_front();
          if (m_data_x !== 8'(exp_v)) begin
            errors++; $display("FAIL x_data[%0d]: got %0h, required %0h", xk, m_data_x, 8'(exp_v));
          end
        end
        if (xk < X_SIZE) rx_x[xk] = $signed(m_data_x);
        xk++;
      end
      if (m_valid_f && m_ready_f) begin
        checks++;
        if (fq.size() == 0) begin
          errors++; $display("FAIL f_extra: beat %0d beyond vector end", fk);
        end else begin
          exp_v = fq.pop_front();
          if (m_data_f !== 8'(exp_v)) begin
            errors++; $display("FAIL f_data[%0d]: got %0h, required %0h", fk, m_data_f, 8'(exp_v));
          end
        end
        if (fk < F_SIZE) rx_f[fk] = $signed(m_data_f);
        fk++;
      end
      if (s_valid_y && s_ready_y) yk++;
      pv_x = m_valid_x; pr_x = m_ready_x; pd_x = m_data_x;
      pv_f = m_valid_f; pr_f = m_ready_f; pd_f = m_data_f;
      if (done) got_done = 1'b1;
      else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL busy: got %b mid-job, required 1", busy);
        end
      end

      if (abort_at > 0 && xk == abort_at) begin
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_valid_x, m_valid_f, s_ready_y, m_data_x, m_data_f, y_count} !== '0) begin
          errors++;
          $display("FAIL mid_reset: busy=%b done=%b vx=%b vf=%b ry=%b dx=%0h df=%0h yc=%0d, required all 0",
                   busy, done, m_valid_x, m_valid_f, s_ready_y, m_data_x, m_data_f, y_count);
        end
        s_valid_y = 1'b0; y_stall = 1'b0; m_ready_x = 1'b1; m_ready_f = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end

    s_valid_y = 1'b0; y_stall = 1'b0; m_ready_x = 1'b1; m_ready_f = 1'b1;
    start = 1'b0; ld_wr_en = 1'b0;
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL timeout: no done pulse, xk=%0d fk=%0d yk=%0d", xk, fk, yk);
    end
    checks++;
    if (xk != X_SIZE || fk != F_SIZE || yk != Y_SIZE) begin
      errors++; $display("FAIL beat_counts: x=%0d f=%0d y=%0d, required %0d %0d %0d",
                         xk, fk, yk, X_SIZE, F_SIZE, Y_SIZE);
    end
    checks++;
    if (y_count !== 7'(Y_SIZE)) begin
      errors++; $display("FAIL y_count: got %0d, required %0d", y_count, Y_SIZE);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s_ready_y !== 1'b0) begin
      errors++; $display("FAIL after_done: done=%b busy=%b ready_y=%b, required 0 0 0", done, busy, s_ready_y);
    end
    @(posedge clk); #1;
    for (int k = 0; k < Y_SIZE; k++) begin
      rd_addr = 7'(k);
      #1;
      exp_v = yq.pop_front();
      checks++;
      if (rd_data !== 21'(exp_v)) begin
        errors++; $display("FAIL ybuf[%0d]: got %0d, required %0d", k, $signed(rd_data), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ld_wr_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; y_stall = 1'b0; m_ready_x = 1'b1; m_ready_f = 1'b1;
    s_valid_y = 1'b0; s_data_y = '0; rd_addr = '0;
    #3;
    checks++;
    if ({busy, done, m_valid_x, m_valid_f, s_ready_y, m_data_x, m_data_f, y_count} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all 0");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < X_SIZE; i++) mx[i] = i;
    for (int j = 0; j < F_SIZE; j++) mf[j] = 1;
    load_all();
    run_job(0, 1'b0, 1'b0, 0);
    rd_addr = 7'd0; #1;
    checks++;
    if (rd_data !== 21'd496) begin
      errors++; $display("FAIL y0_literal: got %0d, required 496", $signed(rd_data));
    end
    rd_addr = 7'd96; #1;
    checks++;
    if (rd_data !== 21'd3568) begin
      errors++; $display("FAIL y96_literal: got %0d, required 3568", $signed(rd_data));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ready_toggle();
    run_job(1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_y_stall();
    run_job(0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ignore_in_send();
    run_job(0, 1'b0, 1'b1, 0);
    // Follow-up job proves X[0] still holds its loaded value.
    run_job(0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_job();
    run_job(0, 1'b0, 1'b0, 50);
    for (int i = 0; i < X_SIZE; i++) mx[i] = 100 - i;
    for (int j = 0; j < F_SIZE; j++) mf[j] = j - 16;
    load_all();
    run_job(0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sign();
    for (int i = 0; i < X_SIZE; i++) mx[i] = -128;
    for (int j = 0; j < F_SIZE; j++) mf[j] = -128;
    load_all();
    run_job(0, 1'b0, 1'b0, 0);
    rd_addr = 7'd50; #1;
    checks++;
    if (rd_data !== 21'(524288)) begin
      errors++; $display("FAIL sign_pos: got %0d, required 524288", $signed(rd_data));
    end
    for (int j = 0; j < F_SIZE; j++) mf[j] = 127;
    load_all();
    run_job(1, 1'b0, 1'b0, 0);
    rd_addr = 7'd50; #1;
    checks++;
    if (rd_data !== 21'(-520192)) begin
      errors++; $display("FAIL sign_neg: got %0d, required -520192", $signed(rd_data));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_y_stall();
    test_ignore_in_send();
    test_reset_mid_job();
    test_sign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
